// File: rtl/spi_slave_frame.sv
// spi_slave_frame: multi-word SPI slave clocked entirely by sclk.
// Words are shifted in on simo and out on somi while ss is held. Transmit
// words come from an internal TX FIFO, and FILL is sent when the FIFO is empty.
// Define SPI_SLAVE_WORD_CNT_EN to build the per-frame word counter.
// When it is not defined, word_cnt is tied to zero.
`timescale 1ns/1ps
module spi_slave_frame #(
    parameter int                DWIDTH    = 8,
    parameter int                DEPTH     = 4,
    parameter bit                MSB_FIRST = 1'b1,
    parameter logic [DWIDTH-1:0] FILL      = {DWIDTH{1'b1}}
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              ss,
    input  logic              simo,
    output logic              somi,
    input  logic [DWIDTH-1:0] tx_data,
    input  logic              tx_wr,
    output logic              tx_full,
    output logic              tx_empty,
    output logic [DWIDTH-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              frame_abort,
    output logic [15:0]       word_cnt
);

    localparam int BW = $clog2(DWIDTH);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [BW-1:0] BCNT_LAST = BW'(DWIDTH - 1);
    localparam logic [BW-1:0] BCNT_ONE  = BW'(1);
    localparam logic [BW-1:0] BCNT_ZERO = BW'(0);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    logic [BW-1:0]     bcnt_r;
    logic [DWIDTH-1:0] tx_shift_r;
    logic [DWIDTH-2:0] rx_part_r;
    logic [DWIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]     wptr_r;
    logic [PW-1:0]     rptr_r;
    logic [CW-1:0]     count_r;

    logic              word_start_s;
    logic              pop_s;
    logic              push_s;
    logic              first_bit_s;
    logic              next_bit_s;
    logic [DWIDTH-1:0] load_word_s;
    logic [DWIDTH-1:0] load_shift_s;
    logic [DWIDTH-1:0] tx_next_shift_s;
    logic [DWIDTH-1:0] rx_full_s;
    logic [DWIDTH-2:0] rx_part_next_s;

    assign tx_full  = (count_r == CNT_FULL);
    assign tx_empty = (count_r == CNT_ZERO);

    // FIFO handshakes, word selection and bit-order steering for both shifters.
    always_comb begin
        word_start_s = ss & (bcnt_r == BCNT_ZERO);
        pop_s        = word_start_s & (count_r != CNT_ZERO);
        push_s       = tx_wr & (count_r != CNT_FULL);
        if (pop_s) begin
            load_word_s = mem_r[rptr_r];
        end else begin
            load_word_s = FILL;
        end
        if (MSB_FIRST) begin
            first_bit_s     = load_word_s[DWIDTH-1];
            load_shift_s    = {load_word_s[DWIDTH-2:0], 1'b0};
            next_bit_s      = tx_shift_r[DWIDTH-1];
            tx_next_shift_s = {tx_shift_r[DWIDTH-2:0], 1'b0};
            rx_full_s       = {rx_part_r, simo};
            rx_part_next_s  = rx_full_s[DWIDTH-2:0];
        end else begin
            first_bit_s     = load_word_s[0];
            load_shift_s    = {1'b0, load_word_s[DWIDTH-1:1]};
            next_bit_s      = tx_shift_r[0];
            tx_next_shift_s = {1'b0, tx_shift_r[DWIDTH-1:1]};
            rx_full_s       = {simo, rx_part_r};
            rx_part_next_s  = rx_full_s[DWIDTH-1:1];
        end
    end

    // TX FIFO storage; stale contents are harmless once the pointers reset.
    always_ff @(posedge sclk) begin
        if (push_s) begin
            mem_r[wptr_r] <= tx_data;
        end
    end

    // TX FIFO pointers and occupancy; a concurrent push and pop leaves the count unchanged.
    always_ff @(posedge sclk) begin
        if (rst) begin
            wptr_r  <= {PW{1'b0}};
            rptr_r  <= {PW{1'b0}};
            count_r <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end else begin
                wptr_r <= wptr_r;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end else begin
                rptr_r <= rptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Bit sequencer: word start, mid-word shift, last bit and abort on ss loss.
    always_ff @(posedge sclk) begin
        if (rst) begin
            bcnt_r      <= BCNT_ZERO;
            tx_shift_r  <= {DWIDTH{1'b0}};
            rx_part_r   <= {(DWIDTH-1){1'b0}};
            somi        <= 1'b0;
            rx_data     <= {DWIDTH{1'b0}};
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
            if (!ss) begin
                // A partial word is dropped. Its popped TX word is not requeued.
                frame_abort <= (bcnt_r != BCNT_ZERO);
                bcnt_r      <= BCNT_ZERO;
            end else if (bcnt_r == BCNT_ZERO) begin
                tx_shift_r  <= load_shift_s;
                somi        <= first_bit_s;
                rx_part_r   <= rx_part_next_s;
                tx_underrun <= ~pop_s;
                bcnt_r      <= BCNT_ONE;
            end else begin
                tx_shift_r <= tx_next_shift_s;
                somi       <= next_bit_s;
                rx_part_r  <= rx_part_next_s;
                if (bcnt_r == BCNT_LAST) begin
                    rx_data  <= rx_full_s;
                    rx_valid <= 1'b1;
                    bcnt_r   <= BCNT_ZERO;
                end else begin
                    bcnt_r <= bcnt_r + BCNT_ONE;
                end
            end
        end
    end

`ifdef SPI_SLAVE_WORD_CNT_EN
    // Completed-word counter for the current frame, saturating, cleared while idle.
    always_ff @(posedge sclk) begin
        if (rst) begin
            word_cnt <= 16'h0000;
        end else if (!ss) begin
            word_cnt <= 16'h0000;
        end else if ((bcnt_r == BCNT_LAST) && (word_cnt != 16'hFFFF)) begin
            word_cnt <= word_cnt + 16'h0001;
        end else begin
            word_cnt <= word_cnt;
        end
    end
`else
    assign word_cnt = 16'h0000;
`endif

endmodule

// File: doc/spi_slave_frame.md
# spi_slave_frame

Parametrised SPI slave for multi-word frames. It runs entirely in the `sclk` domain and shifts `DWIDTH`-bit words in on `simo` and out on `somi` for as long as `ss` is held. Transmit words come from an internal `DEPTH`-entry TX FIFO and fall back to a fill pattern on underrun. Received words are presented with a one-cycle valid strobe. The block sits between the SPI pins and the local register/command logic and replaces the single-word, MSB-only slave used previously.

## Interface
Parameters:
- `DWIDTH`, 8: word width in bits, ≥ 2.
- `DEPTH`, 4: TX FIFO entries, power of two, ≥ 2.
- `MSB_FIRST`, 1: 1 = MSB shifted first on both lines; 0 = LSB first.
- `FILL`, all-ones (`{DWIDTH{1'b1}}`): word transmitted when the TX FIFO is empty at a word boundary.

Ports:
- `sclk` in 1: single clock for the block, rising edge only. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `ss` in 1: slave select, active-high, sampled on `sclk`.
- `simo` in 1: serial data in.
- `somi` out 1: serial data out, registered.
- `tx_data` in DWIDTH: word to queue for transmit.
- `tx_wr` in 1: push `tx_data` into the TX FIFO.
- `tx_full` out 1: TX FIFO holds `DEPTH` words.
- `tx_empty` out 1: TX FIFO holds 0 words.
- `rx_data` out DWIDTH: last complete received word.
- `rx_valid` out 1: one-cycle strobe, `rx_data` is new.
- `tx_underrun` out 1: one-cycle strobe, `FILL` was loaded at a word boundary.
- `frame_abort` out 1: one-cycle strobe, `ss` dropped mid-word.
- `word_cnt` out 16: words completed in the current frame (see Configuration).

## Operation
Reset values:
- `somi=0`, `rx_data=0`, `rx_valid=0`, `tx_underrun=0`, `frame_abort=0`, `word_cnt=0`.
- FIFO empty, so `tx_empty=1` and `tx_full=0`.
- Bit counter `bcnt=0`.

State is implicit in `bcnt` (0..DWIDTH-1):
- IDLE: `ss=0`. `bcnt` is held at 0, `word_cnt` is cleared, and `somi` holds its last value.
- SHIFT, word start: `ss=1` and `bcnt=0`.
  - Pop the FIFO head into `tx_shift`. If the FIFO is empty, load `FILL` instead and pulse `tx_underrun`.
  - `somi` ← first bit of the loaded word (bit DWIDTH-1 if `MSB_FIRST`, else bit 0).
  - Sample `simo` into the rx shift position for bit 0.
  - `bcnt` ← 1.
- SHIFT, mid-word: `ss=1` and `0<bcnt<DWIDTH-1`.
  - Sample `simo` and drive the next tx bit on `somi`.
  - `bcnt` increments.
- SHIFT, last bit: `ss=1` and `bcnt=DWIDTH-1`.
  - Sample the final bit and drive the final tx bit.
  - `bcnt` wraps to 0.
  - Next edge: `rx_data` ← assembled word, `rx_valid=1`, `word_cnt` increments (saturating at 0xFFFF).
- Abort: `ss=0` while `bcnt≠0`.
  - The partial rx word is discarded and `rx_data` is unchanged.
  - `bcnt` ← 0 and `frame_abort` pulses.
  - The popped tx word is lost; it is not re-queued.
- Bit order:
  - `MSB_FIRST=1`: the first sampled bit lands at bit DWIDTH-1.
  - `MSB_FIRST=0`: the first sampled bit lands at bit 0.

TX FIFO:
- Push on `tx_wr & ~tx_full`. `tx_wr` while full is dropped silently.
- Occupancy count is `$clog2(DEPTH)+1` bits. Pointers wrap modulo `DEPTH`.
- Simultaneous push and pop when not empty: count is unchanged and both operations occur.
- Push into an empty FIFO on the same edge as a word start: the pop sees empty, so `FILL` is sent and `tx_underrun` pulses. The pushed word is stored for the next word.
- `tx_full`/`tx_empty` are derived from the registered count and reflect the edge's push/pop one cycle later.

Reset mid-operation: all state returns to its reset value on the next edge regardless of `ss`. FIFO contents are discarded.

## Timing
- `somi` changes on the same `sclk` rising edge that samples `simo`. The bit for word position k appears after edge k.
- `rx_valid` is high exactly one cycle, on the cycle after the edge that sampled the last bit. `rx_data` is stable until the next `rx_valid`.
- Back-to-back words need no idle edge. The edge after the last bit is the next word's start edge.
- Latency from the `tx_wr` edge to eligibility at a word start: 1 edge.
- `tx_underrun` and `frame_abort` are registered single-cycle strobes.

## Configuration
- `SPI_SLAVE_WORD_CNT_EN` defined: the `word_cnt` counter is implemented as described above.
- Not defined: the counter logic is removed and `word_cnt` is tied to 0. All other behaviour is identical.

## Test plan
- Word exchange, `DWIDTH=8`, `MSB_FIRST=1`:
  - Stimulus: push `0xA5`, hold `ss`, drive `simo` with `0x3C` MSB first for 8 edges.
  - Required: `somi` sequence is 1,0,1,0,0,1,0,1. `rx_data=0x3C` with `rx_valid` for 1 cycle.
- LSB-first build (`MSB_FIRST=0`):
  - Stimulus: push `0x01`, shift in `0x80` LSB first.
  - Required: first `somi` bit is 1. `rx_data=0x80`.
- Multi-word frame and counter:
  - Stimulus: push `0x11`, `0x22`, `0x33`; hold `ss` for 24 edges.
  - Required: three `rx_valid` pulses 8 edges apart, tx order `0x11`, `0x22`, `0x33`, `word_cnt=3` (with the macro defined), `tx_empty=1` at the end.
- Underrun and fill:
  - Stimulus: empty FIFO, `ss` high for 8 edges.
  - Required: `somi` sends `0xFF`, `tx_underrun` pulses at the start edge.
- FIFO full:
  - Stimulus: `DEPTH=4`, push 5 words with `ss=0`.
  - Required: `tx_full=1` after the 4th push. The 5th push is dropped and the first 4 words are transmitted in order.
- Abort and reset:
  - Stimulus: deassert `ss` after 5 bits.
  - Required: `frame_abort` pulse, no `rx_valid`, `rx_data` unchanged, next frame starts at bit 0.
  - Stimulus: assert `rst` mid-word.
  - Required: all outputs at their reset values and FIFO empty.
